// File: rtl/key_schedule_ctrl_pkg.sv
// Shared AES-128 key-schedule constants, controller state encoding and the
// S-box / round-constant lookups used by the expansion round.
package key_schedule_ctrl_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_KEY_W      = 128;
  localparam int AES_RKEY_IDX_W = 4;

  typedef enum logic {
    KS_IDLE = 1'b0,
    KS_RUN  = 1'b1
  } ks_state_e;

  // Byte 0x00 sits in the most significant byte of the first row.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    logic [10:0] msb;
    msb = 11'd2047 - {b, 3'b000};
    return AES_SBOX[msb -: 8];
  endfunction

  function automatic logic [7:0] aes_rcon(input logic [AES_RKEY_IDX_W-1:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Key-load and round-key read bundle between the round controllers (master)
// and the key-schedule controller (slave).
interface key_schedule_ctrl_if;
  import key_schedule_ctrl_pkg::*;

  logic                      start;
  logic [AES_KEY_W-1:0]      key_in;
  logic                      busy;
  logic                      done;
  logic                      key_valid;
  logic [AES_RKEY_IDX_W-1:0] rd_addr;
  logic [AES_KEY_W-1:0]      rd_key;

  modport master (
    output start, key_in, rd_addr,
    input  busy, done, key_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_addr,
    output busy, done, key_valid, rd_key
  );

endinterface

// File: rtl/singleKeyExpansion.sv
// One combinational AES-128 key-expansion round: derives round key keyNum
// from round key keyNum-1.
module singleKeyExpansion
  import key_schedule_ctrl_pkg::*;
(
  input  logic [AES_KEY_W-1:0]      keyInput,
  input  logic [AES_RKEY_IDX_W-1:0] keyNum,
  output logic [AES_KEY_W-1:0]      keyOutput
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = keyInput[127:96];
  assign w1 = keyInput[95:64];
  assign w2 = keyInput[63:32];
  assign w3 = keyInput[31:0];

  // RotWord then SubWord on the last word, rcon folded into the top byte.
  assign temp = {aes_sbox(w3[23:16]), aes_sbox(w3[15:8]),
                 aes_sbox(w3[7:0]),   aes_sbox(w3[31:24])}
              ^ {aes_rcon(keyNum), 24'h000000};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign keyOutput = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key-schedule controller: one expansion round per clock
// into an 11-entry round-key bank with a registered read port.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  key_schedule_ctrl_if.slave ks
);

  localparam int BANK_DEPTH = AES_NUM_ROUNDS + 1;
  localparam logic [AES_RKEY_IDX_W-1:0] LAST_ROUND = AES_RKEY_IDX_W'(AES_NUM_ROUNDS);

  ks_state_e                 state, state_nxt;
  logic [AES_RKEY_IDX_W-1:0] round, round_nxt;
  logic [AES_KEY_W-1:0]      work, work_nxt;
  logic [AES_KEY_W-1:0]      exp_key;
  logic [AES_KEY_W-1:0]      bank [BANK_DEPTH];
  logic                      bank_we;
  logic [AES_RKEY_IDX_W-1:0] bank_waddr;
  logic [AES_KEY_W-1:0]      bank_wdata;
  logic                      done_q, done_nxt;
  logic                      valid_q, valid_nxt;
  logic [AES_KEY_W-1:0]      rd_key_q;
  logic                      round_ok;

  singleKeyExpansion u_expansion (
    .keyInput  (work),
    .keyNum    (round),
    .keyOutput (exp_key)
  );

  // Round 0 or 11..15 in RUN can only come from a corrupted counter.
  assign round_ok = (round != '0) && (round <= LAST_ROUND);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) state <= KS_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      KS_IDLE: if (ks.start) state_nxt = KS_RUN;
      KS_RUN:  if (!round_ok || round == LAST_ROUND) state_nxt = KS_IDLE;
      default: state_nxt = KS_IDLE;
    endcase
  end

  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = round;
    bank_wdata = exp_key;
    work_nxt   = work;
    round_nxt  = round;
    done_nxt   = 1'b0;
    valid_nxt  = valid_q;
    case (state)
      KS_IDLE: begin
        if (ks.start) begin
          bank_we    = 1'b1;
          bank_waddr = '0;
          bank_wdata = ks.key_in;
          work_nxt   = ks.key_in;
          round_nxt  = 4'd1;
          valid_nxt  = 1'b0;
        end
      end
      KS_RUN: begin
        if (round_ok) begin
          bank_we  = 1'b1;
          work_nxt = exp_key;
          if (round == LAST_ROUND) begin
            round_nxt = '0;
            done_nxt  = 1'b1;
            valid_nxt = 1'b1;
          end else begin
            round_nxt = round + 4'd1;
          end
        end else begin
          round_nxt = '0;
        end
      end
      default: round_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round    <= '0;
      work     <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_key_q <= '0;
    end else begin
      round   <= round_nxt;
      work    <= work_nxt;
      done_q  <= done_nxt;
      valid_q <= valid_nxt;
      // Read sees pre-edge bank contents, so a same-cycle write is not forwarded.
      rd_key_q <= (ks.rd_addr <= LAST_ROUND) ? bank[ks.rd_addr] : '0;
    end
  end

  // NOTE: the bank is flops, not SRAM, so it is cleared on reset like any other
  // state; stale keys from an aborted run must not be readable afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BANK_DEPTH; i++) bank[i] <= '0;
    end else if (bank_we) begin
      bank[bank_waddr] <= bank_wdata;
    end
  end

  assign ks.busy      = (state == KS_RUN);
  assign ks.done      = done_q;
  assign ks.key_valid = valid_q;
  assign ks.rd_key    = rd_key_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl against a FIPS-197 style
// key-expansion model built from GF(2^8) arithmetic.
module tb_key_schedule_ctrl;
  import key_schedule_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  key_schedule_ctrl_if ks ();

  key_schedule_ctrl dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model_rk [11];
  logic [127:0] old_rk   [11];

  typedef struct {
    string        name;
    logic [3:0]   addr;
    logic [127:0] exp;
  } rd_vec_t;

  rd_vec_t fips_vec [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    logic [7:0] bx;
    for (int x = 0; x < 256; x++) begin
      bx  = 8'(x);
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] exp_rd(input logic [3:0] a);
    if (a <= 4'd10) return model_rk[a];
    return '0;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_key(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick;
      if (ks.done) seen = 1'b1;
    end
    check_bit("done_within_budget", seen, 1'b1);
  endtask

  task automatic start_key(input logic [127:0] key);
    ks.key_in = key;
    ks.start  = 1'b1;
    tick;
    ks.start  = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] a);
    ks.rd_addr = a;
    tick;
    check_key(name, ks.rd_key, exp_rd(a));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] k, k2, k3, k2_rk10;
    int busy_cnt, done_cnt, accepts, first_acc, second_acc, bad_valid;
    logic prev_busy;
    logic [3:0] prev_addr;

    build_sbox();

    fips_vec[0] = '{"fips_rk1",  4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips_vec[1] = '{"fips_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    fips_vec[2] = '{"fips_rk0",  4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

    rst        = 1'b1;
    ks.start   = 1'b0;
    ks.key_in  = '0;
    ks.rd_addr = '0;
    tick;
    tick;
    rst = 1'b0;
    check_bit("reset_busy",  ks.busy,      1'b0);
    check_bit("reset_done",  ks.done,      1'b0);
    check_bit("reset_valid", ks.key_valid, 1'b0);
    check_key("reset_rd_key", ks.rd_key, '0);

    // FIPS-197 vector: 10 busy cycles, one done pulse
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(k);
    start_key(k);
    check_bit("fips_valid_after_accept", ks.key_valid, 1'b0);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (ks.busy) busy_cnt++;
      if (ks.done) done_cnt++;
      tick;
    end
    check_int("fips_busy_cycles", busy_cnt, 10);
    check_int("fips_done_pulses", done_cnt, 1);
    check_bit("fips_key_valid", ks.key_valid, 1'b1);
    for (int v = 0; v < 3; v++) begin
      ks.rd_addr = fips_vec[v].addr;
      tick;
      check_key(fips_vec[v].name, ks.rd_key, fips_vec[v].exp);
    end
    for (int a = 2; a < 10; a++) read_check("fips_model", 4'(a));

    // start held high for 12 cycles; key_in changes after T0
    k2 = rand_key();
    k3 = rand_key();
    model_expand(k2);
    k2_rk10    = model_rk[10];
    ks.rd_addr = 4'd10;
    ks.key_in  = k2;
    ks.start   = 1'b1;
    prev_busy  = ks.busy;
    accepts    = 0;
    first_acc  = -1;
    second_acc = -1;
    bad_valid  = 0;
    done_cnt   = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (ks.busy && !prev_busy) begin
        accepts++;
        if (accepts == 1) first_acc = i;
        else second_acc = i;
      end
      if (ks.busy && ks.key_valid) bad_valid++;
      if (ks.done) done_cnt++;
      if (i == 11) check_key("held_first_rk10", ks.rd_key, k2_rk10);
      if (i == 0) ks.key_in = k3;
      prev_busy = ks.busy;
    end
    ks.start = 1'b0;
    check_int("held_accepts", accepts, 2);
    check_int("held_first_at", first_acc, 0);
    check_int("held_second_at", second_acc, 11);
    check_int("held_valid_in_run", bad_valid, 0);
    check_int("held_done_pulses", done_cnt, 1);
    wait_done(20);
    check_bit("held_valid_end", ks.key_valid, 1'b1);
    model_expand(k3);
    for (int a = 0; a < 11; a++) read_check("held_second_sched", 4'(a));

    // zero key, all-ones start during RUN must be ignored
    model_expand('0);
    start_key('0);
    tick;
    tick;
    ks.key_in = '1;
    ks.start  = 1'b1;
    tick;
    ks.start  = 1'b0;
    wait_done(20);
    tick;
    tick;
    check_bit("zero_no_restart", ks.busy, 1'b0);
    ks.rd_addr = 4'd10;
    tick;
    check_key("zero_rk10", ks.rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    for (int a = 0; a < 10; a++) read_check("zero_sched", 4'(a));

    // reset at T0+5 aborts without a done pulse
    start_key(rand_key());
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_bit("abort_busy",  ks.busy,      1'b0);
    check_bit("abort_valid", ks.key_valid, 1'b0);
    check_bit("abort_done",  ks.done,      1'b0);
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (ks.done) done_cnt++;
    end
    check_int("abort_no_done", done_cnt, 0);
    ks.rd_addr = 4'd3;
    tick;
    check_key("abort_rd3", ks.rd_key, '0);

    // full address sweep with one-cycle lag
    k = rand_key();
    model_expand(k);
    start_key(k);
    wait_done(20);
    tick;
    prev_addr = 4'd3;
    for (int a = 0; a < 16; a++) begin
      ks.rd_addr = 4'(a);
      check_key("sweep_lag", ks.rd_key, exp_rd(prev_addr));
      tick;
      check_key("sweep", ks.rd_key, exp_rd(4'(a)));
      prev_addr = 4'(a);
    end

    // re-expansion while reading index 5: old at write edge, new after
    old_rk = model_rk;
    k = rand_key();
    model_expand(k);
    ks.rd_addr = 4'd5;
    start_key(k);
    check_bit("reexp_valid_drop", ks.key_valid, 1'b0);
    for (int i = 0; i < 4; i++) tick;
    check_key("reexp_before_write", ks.rd_key, old_rk[5]);
    tick;
    check_key("reexp_at_write_edge", ks.rd_key, old_rk[5]);
    tick;
    check_key("reexp_after_write", ks.rd_key, model_rk[5]);
    wait_done(20);
    check_bit("reexp_valid_end", ks.key_valid, 1'b1);

    // randomized keys, optional ignored start in RUN, random reads
    for (int n = 0; n < 6; n++) begin
      k = rand_key();
      model_expand(k);
      start_key(k);
      if ($urandom_range(0, 1) == 1) begin
        tick;
        ks.key_in = rand_key();
        ks.start  = 1'b1;
        tick;
        ks.start  = 1'b0;
      end
      wait_done(20);
      check_bit("rand_valid", ks.key_valid, 1'b1);
      for (int r = 0; r < 8; r++) read_check("rand_read", 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
